dmem_responder: RTL and testbench

- Data-side memory responder for the pipelined core: the slave end of the core's data port (mem_w, Addr_out, Data_out, dm_ctrl in; Data_in out).
- Contains a word-organised RAM with byte-lane writes and RISC-V load extension.
- Adds a small MMIO page: LED register, free-running cycle counter, and a 4-entry console byte FIFO drained by an external valid/ready consumer.
- Reads are combinational, because the core samples Data_in in the same cycle into MEM/WB. Writes commit on the rising clock edge.

---
 rtl/dmem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory slave for the pipelined core.
// Word-organised RAM with byte-lane stores and RISC-V load extension,
// plus a 16-byte MMIO page holding the LED register, a free-running
// cycle counter and a 4-entry console byte FIFO (first-word fall-through).
// Loads are combinational because the core captures rdata in the same
// cycle; all state changes happen on the rising edge.
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        misalign_err
);

  localparam logic [2:0] CTRL_WORD  = 3'b000;
  localparam logic [2:0] CTRL_HALF  = 3'b001;
  localparam logic [2:0] CTRL_HALFU = 3'b010;
  localparam logic [2:0] CTRL_BYTE  = 3'b011;
  localparam logic [2:0] CTRL_BYTEU = 3'b100;

  localparam logic [1:0] OFF_LED     = 2'd0;
  localparam logic [1:0] OFF_CYCLE   = 2'd1;
  localparam logic [1:0] OFF_CONSOLE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // Storage
  logic [31:0] ram [DEPTH];
  logic [7:0]  fifo_mem [4];

  // State registers
  logic [31:0] cycle_cnt;
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;

  // Access decode
  logic          is_word;
  logic          is_half;
  logic          is_byte;
  logic          is_signed;
  logic          reserved;
  logic          misaligned;
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  // Store control
  logic        store_ok;
  logic        ram_we;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic        mmio_wr;
  logic        led_we;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;

  assign ram_hit  = (addr[31:AW+2] == '0);
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
  assign word_idx = addr[AW+1:2];
  assign ram_word = ram[word_idx];

  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign con_valid  = !fifo_empty;
  assign con_data   = fifo_mem[rd_ptr];

  // Classify the access size from dm_ctrl; unknown codes are reserved.
  always_comb begin
    is_word   = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    reserved  = 1'b0;
    case (dm_ctrl)
      CTRL_WORD:  is_word = 1'b1;
      CTRL_HALF:  begin is_half = 1'b1; is_signed = 1'b1; end
      CTRL_HALFU: is_half = 1'b1;
      CTRL_BYTE:  begin is_byte = 1'b1; is_signed = 1'b1; end
      CTRL_BYTEU: is_byte = 1'b1;
      default:    reserved = 1'b1;
    endcase
  end

  // Alignment check; reserved sizes are treated as misaligned.
  always_comb begin
    if (reserved) begin
      misaligned = 1'b1;
    end else if (is_half) begin
      misaligned = addr[0];
    end else if (is_word) begin
      misaligned = (addr[1:0] != 2'b00);
    end else begin
      misaligned = 1'b0;
    end
  end

  // Pick the addressed byte and halfword out of the RAM word.
  always_comb begin
    case (addr[1:0])
      2'd0:    sel_byte = ram_word[7:0];
      2'd1:    sel_byte = ram_word[15:8];
      2'd2:    sel_byte = ram_word[23:16];
      2'd3:    sel_byte = ram_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    if (addr[1]) begin
      sel_half = ram_word[31:16];
    end else begin
      sel_half = ram_word[15:0];
    end
  end

  // Combinational load data: RAM with extension, MMIO word registers, else zero.
  always_comb begin
    rdata = 32'h0000_0000;
    if (misaligned) begin
      rdata = 32'h0000_0000;
    end else if (ram_hit) begin
      if (is_word) begin
        rdata = ram_word;
      end else if (is_half) begin
        rdata = {{16{is_signed & sel_half[15]}}, sel_half};
      end else begin
        rdata = {{24{is_signed & sel_byte[7]}}, sel_byte};
      end
    end else if (mmio_hit && is_word) begin
      case (addr[3:2])
        OFF_LED:     rdata = {16'h0000, led};
        OFF_CYCLE:   rdata = cycle_cnt;
        OFF_CONSOLE: rdata = 32'h0000_0000;
        OFF_STATUS:  rdata = {27'h0000000, count, fifo_full, fifo_empty};
        default:     rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Store lane enables and replicated write data by access size.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = wdata;
    if (is_word) begin
      byte_en = 4'b1111;
      wr_word = wdata;
    end else if (is_half) begin
      byte_en = addr[1] ? 4'b1100 : 4'b0011;
      wr_word = {2{wdata[15:0]}};
    end else if (is_byte) begin
      byte_en = 4'b0001 << addr[1:0];
      wr_word = {4{wdata[7:0]}};
    end else begin
      byte_en = 4'b0000;
      wr_word = wdata;
    end
  end

  assign store_ok = mem_w && !misaligned && !reset;
  assign ram_we   = store_ok && ram_hit;
  assign mmio_wr  = store_ok && mmio_hit && is_word;
  assign led_we   = mmio_wr && (addr[3:2] == OFF_LED);
  assign push_req = mmio_wr && (addr[3:2] == OFF_CONSOLE);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is refused.
  assign push     = push_req && !fifo_full;
  assign pop      = con_valid && con_ready;

  // RAM byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && byte_en[i]) begin
        ram[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Console FIFO payload storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  // Control registers: LED, cycle counter, sticky error flag, FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      led          <= 16'h0000;
      cycle_cnt    <= 32'h0000_0000;
      misalign_err <= 1'b0;
      rd_ptr       <= 2'd0;
      wr_ptr       <= 2'd0;
      count        <= 3'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mem_w && misaligned) begin
        misalign_err <= 1'b1;
      end
      if (led_we) begin
        led <= wdata[15:0];
      end
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-array / queue model of the
// memory map is stepped on every rising edge and compared on every falling
// edge; directed sequences pin the model with hand-computed values, then a
// randomized phase exercises RAM, MMIO and unmapped accesses.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit chk_rdata = 1'b0;

  // Behavioural model state
  logic [7:0]  mb [4096];
  logic [15:0] m_led;
  logic [31:0] m_cyc;
  logic        m_err;
  logic [7:0]  mq [$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .AW(10), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .dm_ctrl(dm_ctrl), .rdata(rdata), .led(led), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready), .misalign_err(misalign_err)
  );

  function automatic int size_of(logic [2:0] c);
    case (c)
      3'd0:          return 4;
      3'd1, 3'd2:    return 2;
      3'd3, 3'd4:    return 1;
      default:       return 0;
    endcase
  endfunction

  function automatic bit is_mis(logic [31:0] a, logic [2:0] c);
    int sz = size_of(c);
    return (sz == 0) || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a, logic [2:0] c);
    int sz = size_of(c);
    int base;
    logic [31:0] v;
    int n;
    if (is_mis(a, c)) return 32'h0;
    if (a < 32'd4096) begin
      base = int'(a) - (int'(a) % sz);
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[base + i]) << (8 * i));
      if (c == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (c == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
      return v;
    end
    if (a[31:4] == MB[31:4] && sz == 4) begin
      n = mq.size();
      case (a[3:0])
        4'h0:    return {16'h0, m_led};
        4'h4:    return m_cyc;
        4'hC:    return (32'(n) << 2) | ((n == 4) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply the edge's effect from the inputs present at the edge.
  always @(posedge clk) begin
    bit full_before;
    int sz;
    int base;
    if (reset) begin
      m_led = 16'h0;
      m_cyc = 32'h0;
      m_err = 1'b0;
      mq.delete();
    end else begin
      m_cyc = m_cyc + 32'd1;
      full_before = (mq.size() == 4);
      if (mq.size() != 0 && con_ready) void'(mq.pop_front());
      if (mem_w) begin
        sz = size_of(dm_ctrl);
        if (is_mis(addr, dm_ctrl)) begin
          m_err = 1'b1;
        end else if (addr < 32'd4096) begin
          base = int'(addr) - (int'(addr) % sz);
          for (int i = 0; i < sz; i++) mb[base + i] = wdata[8*i +: 8];
        end else if (addr[31:4] == MB[31:4] && sz == 4) begin
          if (addr[3:0] == 4'h0) m_led = wdata[15:0];
          if (addr[3:0] == 4'h8 && !full_before) mq.push_back(wdata[7:0]);
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("led", {16'h0, led}, {16'h0, m_led});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
      chk("con_valid", {31'h0, con_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) chk("con_data", {24'h0, con_data}, {24'h0, mq[0]});
      if (chk_rdata) chk("rdata", rdata, m_read(addr, dm_ctrl));
    end
  end

  task automatic drv(bit w, logic [31:0] a, logic [31:0] d, logic [2:0] c);
    mem_w = w; addr = a; wdata = d; dm_ctrl = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, logic [31:0] exp);
    @(negedge clk);
    chk(name, rdata, exp);
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    logic [7:0]  msg [5];
    int r;
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h44; msg[4] = 8'h45;
    reset = 1'b1; con_ready = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 3'd0);
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    drv(1'b0, MB + 32'hC, 32'h0, 3'd0);
    lit("status_after_reset", 32'h0000_0001);
    chk("led_reset", {16'h0, led}, 32'h0);
    chk("err_reset", {31'h0, misalign_err}, 32'h0);
    step();

    // Give the tested RAM window defined contents
    for (int w = 0; w < 32; w++) begin
      drv(1'b1, 32'(w * 4), $urandom, 3'd0);
      step();
    end
    chk_rdata = 1'b1;

    // Store then load; same-cycle read sees the old word (model compare)
    drv(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0); step();
    drv(1'b0, 32'h10, 32'h0, 3'd0); lit("lw_after_sw", 32'hDEAD_BEEF); step();

    // Byte store and extended loads
    drv(1'b1, 32'h10, 32'h1122_3344, 3'd0); step();
    drv(1'b1, 32'h13, 32'h0000_0080, 3'd3); step();
    drv(1'b0, 32'h10, 32'h0, 3'd0); lit("lw_after_sb", 32'h8022_3344); step();
    drv(1'b0, 32'h13, 32'h0, 3'd3); lit("lb", 32'hFFFF_FF80); step();
    drv(1'b0, 32'h13, 32'h0, 3'd4); lit("lbu", 32'h0000_0080); step();
    drv(1'b0, 32'h12, 32'h0, 3'd1); lit("lh", 32'hFFFF_8022); step();
    drv(1'b0, 32'h12, 32'h0, 3'd2); lit("lhu", 32'h0000_8022); step();

    // Misaligned store dropped, flag sticky
    drv(1'b1, 32'h20, 32'hCAFE_F00D, 3'd0); step();
    drv(1'b1, 32'h21, 32'h0000_BEEF, 3'd1); lit("sh_mis_rdata", 32'h0); step();
    drv(1'b0, 32'h20, 32'h0, 3'd0); lit("ram_unchanged", 32'hCAFE_F00D);
    chk("err_set", {31'h0, misalign_err}, 32'h1); step();
    drv(1'b0, 32'h22, 32'h0, 3'd0); lit("lw_mis_rdata", 32'h0); step();
    repeat (3) step();
    @(negedge clk); chk("err_held", {31'h0, misalign_err}, 32'h1);

    // LED register
    drv(1'b1, MB, 32'h1234_ABCD, 3'd0); step();
    drv(1'b0, MB, 32'h0, 3'd0); lit("led_read", 32'h0000_ABCD);
    chk("led_port", {16'h0, led}, 32'h0000_ABCD); step();

    // Cycle counter delta
    drv(1'b0, MB + 32'h4, 32'h0, 3'd0);
    @(negedge clk); v1 = rdata;
    repeat (7) step();
    @(negedge clk); v2 = rdata;
    chk("cycle_delta", v2 - v1, 32'd7);
    step();

    // FIFO fill beyond capacity with consumer stalled
    con_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, MB + 32'h8, {24'h0, msg[i]}, 3'd0); step();
    end
    drv(1'b0, MB + 32'hC, 32'h0, 3'd0); lit("status_full", 32'h0000_0012);
    con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", {24'h0, con_data}, {24'h0, msg[i]});
      step();
      @(negedge clk);
    end
    con_ready = 1'b0;
    chk("status_drained", rdata, 32'h0000_0001);
    step();

    // Push while full and popping: push refused, count 4->3
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, MB + 32'h8, 32'h61 + 32'(i), 3'd0); step();
    end
    con_ready = 1'b1;
    drv(1'b1, MB + 32'h8, 32'h58, 3'd0); step();
    con_ready = 1'b0;
    drv(1'b0, MB + 32'hC, 32'h0, 3'd0); lit("status_full_pushpop", 32'h0000_000C);
    chk("head_after_pushpop", {24'h0, con_data}, 32'h62);
    step();

    // Reset with data in the FIFO
    reset = 1'b1; step();
    @(negedge clk);
    chk("con_valid_reset", {31'h0, con_valid}, 32'h0);
    chk("led_reset2", {16'h0, led}, 32'h0);
    chk("err_reset2", {31'h0, misalign_err}, 32'h0);
    reset = 1'b0; step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       addr = $urandom_range(0, 127);
      else if (r < 8)  addr = MB + 32'($urandom_range(0, 15));
      else if (r == 8) addr = 32'h0001_0000 | 32'($urandom_range(0, 255));
      else             addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      dm_ctrl   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      mem_w     = ($urandom_range(0, 9) < 4);
      wdata     = $urandom;
      con_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
